frame_dump_ctl: RTL and testbench
=================================

# frame_dump_ctl

Synthesizable frame counter and dump-window sequencer for the MiST simulation harness. It sits directly upstream of the dump controller. It samples the video vertical sync and the download LED, and produces the 32-bit `frame_cnt` the dump controller compares against. It also produces registered dump-window strobes and a sticky finish request, so start and stop frame selection no longer depend on testbench-side `initial` blocks.

## Interface
Parameters:
- `LOADROM`, 0: 1 = hold counting until the first download completes (falling edge of `led`); 0 = count from reset release.
- `DUMP_START`, 0: frame number at which the dump window opens.
- `DUMP_LEN`, 0: window length in frames; 0 = unlimited.
- `MAX_FRAME`, 0: frame number at which `finish` asserts; 0 = never.
- `VS_NEG`, 1: 1 = a frame boundary is the falling edge of `VGA_VS`; 0 = the rising edge.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `VGA_VS`  in  1  vertical sync, asynchronous to `clk`.
- `led`  in  1  download-active indicator, asynchronous; high while the ROM is downloading.
- `frame_cnt`  out  32  frames counted since counting started.
- `frame_tick`  out  1  one-cycle pulse on each counted frame boundary.
- `dump_on`  out  1  high while the dump window is open.
- `dump_start`  out  1  one-cycle pulse when the window opens.
- `dump_stop`  out  1  one-cycle pulse when the window closes.
- `finish`  out  1  sticky end-of-simulation request.

## Operation
- `VGA_VS` and `led` each pass through 2-flop synchronizers. A third register on each synchronizer output drives edge detection.
- FSM states:
  - WAIT: counter held at 0, no ticks.
  - COUNT: counting, window closed.
  - DUMP: counting, window open.
  - DONE: `finish` = 1; the counter keeps running and `dump_on` = 0.
- State transitions:
  - Reset → WAIT.
  - WAIT → COUNT: when `LOADROM` = 0, the first cycle after reset release. When `LOADROM` = 1, on a synchronized `led` falling edge.
  - In both cases, if `DUMP_START` = 0 the FSM enters DUMP directly and `dump_start` pulses on that entry cycle.
  - COUNT → DUMP: on the tick where `frame_cnt` becomes `DUMP_START`.
  - DUMP → COUNT: when `DUMP_LEN` ≠ 0, on the tick where `frame_cnt` becomes `DUMP_START` + `DUMP_LEN`. `dump_stop` pulses. The window never reopens; a later match is ignored, tracked by a "done once" flag.
  - Any non-WAIT state → DONE: when `MAX_FRAME` ≠ 0, on the tick where `frame_cnt` becomes `MAX_FRAME`. If leaving DUMP, `dump_stop` pulses on the same cycle.
- Tick rule:
  - In every state except WAIT, a selected `VGA_VS` edge produces `frame_tick` = 1 for one cycle.
  - `frame_cnt` ← `frame_cnt` + 1 on that same edge.
  - Comparisons use the incremented value.
- Arithmetic and widths: `frame_cnt` is unsigned 32-bit and wraps from 0xFFFFFFFF to 0. The stop comparison uses the 32-bit truncated sum `DUMP_START` + `DUMP_LEN`.
- Download restart when `LOADROM` = 1: a synchronized `led` rising edge in COUNT or DUMP sends the FSM to WAIT and clears `frame_cnt` to 0. If the FSM was in DUMP, `dump_stop` pulses. The "done once" flag clears. DONE ignores `led`.
- Simultaneous events on one tick:
  - Finish match and start match together: the FSM goes to DONE and `dump_start` does not pulse.
  - Finish match and stop match together: a single `dump_stop` pulse.
  - `led` rising edge and a `VGA_VS` edge in the same cycle: the `led` edge wins, no tick occurs, and the counter clears.

## Timing
- Reset values: `frame_cnt` = 0, all 1-bit outputs = 0, synchronizers = 0, FSM = WAIT.
- Input to tick latency: 3 `clk` rising edges after the `VGA_VS` edge, counting 2 synchronizer stages plus the edge register. `frame_tick`, the new `frame_cnt`, `dump_on`, `dump_start`/`dump_stop` and `finish` all update on that same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `led` to WAIT exit latency is likewise 3 cycles.
- `VGA_VS` pulses narrower than 2 `clk` periods may be lost.
- An asserted `rst_n` mid-window clears `dump_on` immediately and asynchronously, with no `dump_stop` pulse.

## Test plan
- `LOADROM`=0, `DUMP_START`=3, `DUMP_LEN`=2, 6 VS falling edges → `frame_tick` ×6 and `frame_cnt` reaches 6. `dump_start` pulses once as `frame_cnt` becomes 3, `dump_stop` pulses once at 5, and `dump_on` is high across frames 3–4.
- `LOADROM`=1, VS toggling while `led`=1 → `frame_cnt` stays 0. Drop `led` → counting starts, and the first tick arrives 3 cycles after the next VS falling edge, giving `frame_cnt` = 1.
- `MAX_FRAME`=4, `DUMP_START`=4 → at the 4th tick `finish` = 1, no `dump_start`, `dump_on` stays 0, and `finish` stays 1 for 10 further frames.
- `LOADROM`=1, `DUMP_START`=2, `DUMP_LEN`=0, raise `led` at frame 5 → `dump_stop` pulses and `frame_cnt` = 0. After `led` falls, the window reopens when `frame_cnt` next becomes 2.
- Preload `frame_cnt` to 0xFFFFFFFE via force, 2 ticks → value reads 0xFFFFFFFF then 0x00000000 with no spurious strobes.
- Drop `rst_n` while in DUMP → all outputs read 0 immediately without waiting for a clock, and no `dump_stop` pulse occurs.

Source files
------------

// File: rtl/frame_dump_ctl.sv
// frame_dump_ctl: counts video frames from a synchronized vertical sync and
// sequences a one-shot dump window plus a sticky end-of-run request.
module frame_dump_ctl #(
  parameter bit          LOADROM    = 1'b0,
  parameter logic [31:0] DUMP_START = 32'd0,
  parameter logic [31:0] DUMP_LEN   = 32'd0,
  parameter logic [31:0] MAX_FRAME  = 32'd0,
  parameter bit          VS_NEG     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VGA_VS,
  input  logic        led,
  output logic [31:0] frame_cnt,
  output logic        frame_tick,
  output logic        dump_on,
  output logic        dump_start,
  output logic        dump_stop,
  output logic        finish
);

  // Frame number at which the window closes; wraps like the counter does.
  localparam logic [31:0] STOP_FRAME = DUMP_START + DUMP_LEN;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        vs_meta, vs_sync, vs_prev;
  logic        led_meta, led_sync, led_prev;
  logic        vs_edge, led_rise, led_fall;
  logic        done_once, done_once_nxt;
  logic [31:0] cnt_inc, cnt_nxt;
  logic        tick_nxt, start_nxt, stop_nxt;

  // Two-flop synchronizers plus a history register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
      led_meta <= 1'b0;
      led_sync <= 1'b0;
      led_prev <= 1'b0;
    end else begin
      vs_meta  <= VGA_VS;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
      led_meta <= led;
      led_sync <= led_meta;
      led_prev <= led_sync;
    end
  end

  // Edge strobes seen by the sequencer, one cycle wide each.
  always_comb begin
    vs_edge  = VS_NEG ? (vs_prev & ~vs_sync) : (~vs_prev & vs_sync);
    led_rise = ~led_prev & led_sync;
    led_fall = led_prev & ~led_sync;
    cnt_inc  = frame_cnt + 32'd1;
  end

  // Next-state and next-output decisions; finish outranks start and stop.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = frame_cnt;
    tick_nxt      = 1'b0;
    start_nxt     = 1'b0;
    stop_nxt      = 1'b0;
    done_once_nxt = done_once;
    case (state)
      ST_WAIT: begin
        if (!LOADROM || led_fall) begin
          if (DUMP_START == 32'd0) begin
            state_nxt = ST_DUMP;
            start_nxt = 1'b1;
          end else begin
            state_nxt = ST_COUNT;
          end
        end
      end
      ST_COUNT, ST_DUMP: begin
        if (LOADROM && led_rise) begin
          state_nxt     = ST_WAIT;
          cnt_nxt       = 32'd0;
          stop_nxt      = (state == ST_DUMP);
          done_once_nxt = 1'b0;
        end else if (vs_edge) begin
          tick_nxt = 1'b1;
          cnt_nxt  = cnt_inc;
          if ((MAX_FRAME != 32'd0) && (cnt_inc == MAX_FRAME)) begin
            state_nxt = ST_DONE;
            stop_nxt  = (state == ST_DUMP);
          end else if ((state == ST_COUNT) && !done_once && (cnt_inc == DUMP_START)) begin
            state_nxt = ST_DUMP;
            start_nxt = 1'b1;
          end else if ((state == ST_DUMP) && (DUMP_LEN != 32'd0) && (cnt_inc == STOP_FRAME)) begin
            state_nxt     = ST_COUNT;
            stop_nxt      = 1'b1;
            done_once_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (vs_edge) begin
          tick_nxt = 1'b1;
          cnt_nxt  = cnt_inc;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      done_once  <= 1'b0;
      frame_cnt  <= 32'd0;
      frame_tick <= 1'b0;
      dump_on    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_once  <= done_once_nxt;
      frame_cnt  <= cnt_nxt;
      frame_tick <= tick_nxt;
      dump_on    <= (state_nxt == ST_DUMP);
      dump_start <= start_nxt;
      dump_stop  <= stop_nxt;
      finish     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_frame_dump_ctl.sv
// tb_frame_dump_ctl: five differently configured frame_dump_ctl instances share
// the same sync/led/reset stimulus and are checked against a behavioural model.
module tb_frame_dump_ctl;

  localparam int N = 5;
  // Instance order: 0=A 1=B 2=C 3=D 4=E (bit/element 0 is instance A).
  localparam logic [N-1:0]       P_LOADROM = 5'b01010;
  localparam logic [N-1:0]       P_VSNEG   = 5'b11011;
  localparam logic [N-1:0][31:0] P_START   = {32'd1, 32'd0, 32'd4, 32'd2, 32'd3};
  localparam logic [N-1:0][31:0] P_LEN     = {32'd2, 32'd5, 32'd3, 32'd0, 32'd2};
  localparam logic [N-1:0][31:0] P_MAX     = {32'd3, 32'd9, 32'd4, 32'd0, 32'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic VGA_VS = 1'b0;
  logic led = 1'b1;

  logic [31:0] cnt_o [N];
  logic        tick_o [N];
  logic        on_o [N];
  logic        start_o [N];
  logic        stop_o [N];
  logic        fin_o [N];

  int total = 0;
  int bad = 0;
  int tk_cnt [N];
  int st_cnt [N];
  int sp_cnt [N];

  // Behavioural model state: input history plus per-instance window status.
  bit          vs_h1, vs_h2, vs_h3, led_h1, led_h2, led_h3;
  bit          m_run [N], m_win [N], m_fin [N], m_used [N];
  bit          m_tick [N], m_start [N], m_stop [N];
  logic [31:0] m_cnt [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    frame_dump_ctl #(
      .LOADROM   (P_LOADROM[g]),
      .DUMP_START(P_START[g]),
      .DUMP_LEN  (P_LEN[g]),
      .MAX_FRAME (P_MAX[g]),
      .VS_NEG    (P_VSNEG[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .VGA_VS    (VGA_VS),
      .led       (led),
      .frame_cnt (cnt_o[g]),
      .frame_tick(tick_o[g]),
      .dump_on   (on_o[g]),
      .dump_start(start_o[g]),
      .dump_stop (stop_o[g]),
      .finish    (fin_o[g])
    );
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("[TB] FAIL %s (u%0d) got=0x%08h expected=0x%08h @%0t", name, inst, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit vs_v, input bit led_v, input int n);
    @(negedge clk);
    VGA_VS = vs_v;
    led    = led_v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic vsPulse(input int count);
    for (int k = 0; k < count; k++) begin
      applyStimulus(1'b1, led, 3);
      applyStimulus(1'b0, led, 4);
    end
  endtask

  task automatic clearCounters();
    for (int i = 0; i < N; i++) begin
      tk_cnt[i] = 0;
      st_cnt[i] = 0;
      sp_cnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    {vs_h1, vs_h2, vs_h3, led_h1, led_h2, led_h3} = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_win[i] = 0; m_fin[i] = 0; m_used[i] = 0;
      m_tick[i] = 0; m_start[i] = 0; m_stop[i] = 0;
      m_cnt[i] = 32'd0;
    end
  endtask

  // One clock of the frame rules: a frame boundary is seen three edges late.
  task automatic model_step();
    bit vs_r, vs_f, ld_r, ld_f, vs_ev;
    vs_r = !vs_h3 && vs_h2;
    vs_f = vs_h3 && !vs_h2;
    ld_r = !led_h3 && led_h2;
    ld_f = led_h3 && !led_h2;
    for (int i = 0; i < N; i++) begin
      m_tick[i] = 0; m_start[i] = 0; m_stop[i] = 0;
      vs_ev = P_VSNEG[i] ? vs_f : vs_r;
      if (m_fin[i]) begin
        if (vs_ev) begin m_tick[i] = 1; m_cnt[i] = m_cnt[i] + 1; end
      end else if (!m_run[i]) begin
        if (!P_LOADROM[i] || ld_f) begin
          m_run[i] = 1;
          if (P_START[i] == 0) begin m_win[i] = 1; m_start[i] = 1; end
        end
      end else if (P_LOADROM[i] && ld_r) begin
        m_run[i] = 0; m_stop[i] = m_win[i]; m_win[i] = 0;
        m_cnt[i] = 0; m_used[i] = 0;
      end else if (vs_ev) begin
        m_tick[i] = 1;
        m_cnt[i] = m_cnt[i] + 1;
        if (P_MAX[i] != 0 && m_cnt[i] == P_MAX[i]) begin
          m_fin[i] = 1; m_stop[i] = m_win[i]; m_win[i] = 0;
        end else if (!m_win[i] && !m_used[i] && m_cnt[i] == P_START[i]) begin
          m_win[i] = 1; m_start[i] = 1;
        end else if (m_win[i] && P_LEN[i] != 0 && m_cnt[i] == P_START[i] + P_LEN[i]) begin
          m_win[i] = 0; m_stop[i] = 1; m_used[i] = 1;
        end
      end
    end
    vs_h3 = vs_h2; vs_h2 = vs_h1; vs_h1 = VGA_VS;
    led_h3 = led_h2; led_h2 = led_h1; led_h1 = led;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      checkOutput("frame_cnt", i, cnt_o[i], m_cnt[i]);
      checkOutput("frame_tick", i, 32'(tick_o[i]), 32'(m_tick[i]));
      checkOutput("dump_on", i, 32'(on_o[i]), 32'(m_win[i]));
      checkOutput("dump_start", i, 32'(start_o[i]), 32'(m_start[i]));
      checkOutput("dump_stop", i, 32'(stop_o[i]), 32'(m_stop[i]));
      checkOutput("finish", i, 32'(fin_o[i]), 32'(m_fin[i]));
      if (rst_n) begin
        if (tick_o[i])  tk_cnt[i]++;
        if (start_o[i]) st_cnt[i]++;
        if (stop_o[i])  sp_cnt[i]++;
      end
    end
  endtask

  // Cycle-by-cycle comparison against the model, including async reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit nv, nl;
    clearCounters();
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checkOutput("reset_cnt", i, cnt_o[i], 32'd0);
      checkOutput("reset_on", i, 32'(on_o[i]), 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 5);
    clearCounters();

    // Six frames: A opens at 3 and closes at 5; C and E hit their finish frame.
    vsPulse(6);
    checkOutput("A_cnt6", 0, cnt_o[0], 32'd6);
    checkOutput("A_ticks", 0, tk_cnt[0], 32'd6);
    checkOutput("A_starts", 0, st_cnt[0], 32'd1);
    checkOutput("A_stops", 0, sp_cnt[0], 32'd1);
    checkOutput("B_held", 1, cnt_o[1], 32'd0);
    checkOutput("C_finish", 2, 32'(fin_o[2]), 32'd1);
    checkOutput("C_nostart", 2, st_cnt[2], 32'd0);
    checkOutput("E_stops", 4, sp_cnt[4], 32'd1);
    checkOutput("E_finish", 4, 32'(fin_o[4]), 32'd1);
    vsPulse(10);
    checkOutput("C_cnt16", 2, cnt_o[2], 32'd16);
    checkOutput("C_finish_hold", 2, 32'(fin_o[2]), 32'd1);
    checkOutput("C_on_low", 2, 32'(on_o[2]), 32'd0);

    // Download completes; D enters its window at once, B counts the next frame.
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("D_on", 3, 32'(on_o[3]), 32'd1);
    checkOutput("D_starts", 3, st_cnt[3], 32'd1);
    applyStimulus(1'b1, 1'b0, 4);
    @(negedge clk);
    VGA_VS = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("B_tick_early", 1, 32'(tick_o[1]), 32'd0);
    @(posedge clk);
    #1 checkOutput("B_tick_lat3", 1, 32'(tick_o[1]), 32'd1);
    checkOutput("B_cnt1", 1, cnt_o[1], 32'd1);

    // Restart the download at frame 5 and watch B's window reopen at 2.
    vsPulse(4);
    checkOutput("B_cnt5", 1, cnt_o[1], 32'd5);
    checkOutput("D_stops", 3, sp_cnt[3], 32'd1);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("B_restart_cnt", 1, cnt_o[1], 32'd0);
    checkOutput("B_restart_stop", 1, sp_cnt[1], 32'd1);
    applyStimulus(1'b0, 1'b0, 6);
    vsPulse(2);
    checkOutput("B_reopen", 1, st_cnt[1], 32'd2);
    checkOutput("B_on", 1, 32'(on_o[1]), 32'd1);
    checkOutput("D_restarts", 3, st_cnt[3], 32'd2);

    // Counter wrap on A, which is past its window and never finishes.
    applyStimulus(1'b0, 1'b0, 4);
    @(negedge clk);
    force gen_dut[0].u_dut.frame_cnt = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release gen_dut[0].u_dut.frame_cnt;
    vsPulse(1);
    checkOutput("A_wrap_ff", 0, cnt_o[0], 32'hFFFF_FFFF);
    vsPulse(1);
    checkOutput("A_wrap_00", 0, cnt_o[0], 32'd0);
    checkOutput("A_wrap_starts", 0, st_cnt[0], 32'd1);
    checkOutput("A_wrap_stops", 0, sp_cnt[0], 32'd2 - 32'd1);

    // Randomized sync and download activity with occasional resets.
    for (int it = 0; it < 2500; it++) begin
      nv = ~VGA_VS;
      nl = ($urandom_range(0, 24) == 0) ? ~led : led;
      applyStimulus(nv, nl, $urandom_range(2, 7));
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Reset asserted while A's window is open clears everything at once.
    @(posedge clk);
    #3 rst_n = 1'b0;
    VGA_VS = 1'b0;
    led = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 5);
    vsPulse(3);
    checkOutput("A_in_window", 0, 32'(on_o[0]), 32'd1);
    checkOutput("A_cnt3", 0, cnt_o[0], 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput("async_cnt", i, cnt_o[i], 32'd0);
      checkOutput("async_on", i, 32'(on_o[i]), 32'd0);
      checkOutput("async_stop", i, 32'(stop_o[i]), 32'd0);
      checkOutput("async_fin", i, 32'(fin_o[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
